// File: rtl/mem_lsu.sv
// mem_lsu: RV32I load/store unit with read-modify-write sub-word stores.
// Define MEM_LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing alignment.
module mem_lsu #(
    parameter int MEM_WORDS = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_storeData,
    input  logic [31:0] i_memReadData,
    output logic [1:0]  o_ctrlMEM,
    output logic [31:0] o_memAddr,
    output logic [31:0] o_memWriteData,
    output logic        o_stall,
    output logic [31:0] o_loadData,
    output logic        o_loadValid,
    output logic [1:0]  o_fault,
    output logic [31:0] o_badAddr
);
    typedef enum logic {IDLE, RMW_WR} state_t;
    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);
    state_t state, state_nx;
    logic is_ld, is_st, legal, req, half, word, misal, oor, fault, go, rmw;
    logic [4:0] sh;
    logic [31:0] lane, mask, merged, ld_ext, rmw_addr, rmw_data;
    always_comb begin
        is_ld = i_valid && i_memRead && !i_memWrite;
        is_st = i_valid && i_memWrite && !i_memRead;
        legal = is_ld ? (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                      : is_st && !i_funct3[2] && i_funct3[1:0] != 2'b11;
        req = state == IDLE && legal;
        half = i_funct3[1:0] == 2'b01;
        word = i_funct3[1:0] == 2'b10;
        oor = i_addr[31:2] >= WORD_LIMIT;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        misal = (half && i_addr[0]) || (word && i_addr[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        fault = req && (oor || misal);
        go = req && !fault;
        rmw = go && is_st && !word;
        // lane offset ignores the low address bits a naturally aligned access cannot use
        sh = word ? 5'd0 : half ? {i_addr[1], 4'b0000} : {i_addr[1:0], 3'b000};
        lane = i_memReadData >> sh;
        ld_ext = i_funct3 == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                 i_funct3 == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
                 i_funct3 == 3'b100 ? {24'h0, lane[7:0]} :
                 i_funct3 == 3'b101 ? {16'h0, lane[15:0]} : lane;
        mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        merged = (i_memReadData & ~mask) | ((i_storeData << sh) & mask);
        state_nx = rmw ? RMW_WR : IDLE;
        o_ctrlMEM = !i_reset_n ? 2'b00 :
                    state == RMW_WR ? 2'b01 :
                    !go ? 2'b00 :
                    (is_st && word) ? 2'b01 : 2'b10;
        o_stall = i_reset_n && rmw;
        o_memAddr = state == RMW_WR ? rmw_addr : {i_addr[31:2], 2'b00};
        o_memWriteData = state == RMW_WR ? rmw_data : i_storeData;
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            o_loadData <= '0;
            o_loadValid <= 1'b0;
            o_fault <= 2'b00;
            o_badAddr <= '0;
            rmw_addr <= '0;
            rmw_data <= '0;
        end else begin
            state <= state_nx;
            o_loadValid <= go && is_ld;
            o_fault <= fault ? {oor, misal && !oor} : 2'b00;
            if (fault) o_badAddr <= i_addr;
            if (go && is_ld) o_loadData <= ld_ext;
            if (rmw) begin
                rmw_addr <= {i_addr[31:2], 2'b00};
                rmw_data <= merged;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table vectors, directed RMW/reset sequences and random traffic
// checked against a byte-addressed reference model of mem_lsu.
module tb_mem_lsu;
    localparam int MW = 2048;
    logic clk = 0, rst_n = 0, valid = 0, rd = 0, wr = 0;
    logic [2:0] f3 = 0;
    logic [31:0] addr = 0, sdata = 0, rdata = 0;
    logic [1:0] ctrl, fault;
    logic [31:0] maddr, wdata, ld, bad;
    logic stall, lv;
    logic [31:0] mem [MW];
    logic [31:0] ref_mem [MW];
    int wr_count = 0, n_pass = 0, n_total = 0, wc;

    always #5 clk = ~clk;

    mem_lsu #(.MEM_WORDS(MW)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_memRead(rd), .i_memWrite(wr),
        .i_funct3(f3), .i_addr(addr), .i_storeData(sdata), .i_memReadData(rdata),
        .o_ctrlMEM(ctrl), .o_memAddr(maddr), .o_memWriteData(wdata), .o_stall(stall),
        .o_loadData(ld), .o_loadValid(lv), .o_fault(fault), .o_badAddr(bad)
    );

    // data memory: read and write resolve at the negedge of the access cycle
    always @(negedge clk) begin
        if (ctrl[1]) rdata = maddr[31:13] == 0 ? mem[maddr[12:2]] : 32'hDEAD_BEEF;
        if (ctrl[0]) begin
            wr_count++;
            if (maddr[31:13] == 0) mem[maddr[12:2]] = wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    typedef struct {
        logic [1:0] ctrl;
        logic stall, lv, wr;
        logic [31:0] ld, wdata;
        logic [1:0] fault;
        int widx;
    } exp_t;

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        logic [31:0] w;
        w = ref_mem[a[12:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    // reference: a request is a run of n bytes at a naturally aligned byte address
    function automatic exp_t model(input logic v, r, w, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] s);
        exp_t e;
        int n, base;
        longint val;
        logic [31:0] nw;
        e = '{default: 0};
        if (!v || r == w) return e;
        if (r && !(f inside {0, 1, 2, 4, 5})) return e;
        if (w && f > 2) return e;
        if (a / 4 >= MW) begin
            e.fault = 2'b10;
            return e;
        end
        n = 1 << f[1:0];
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        if (a % n != 0) begin
            e.fault = 2'b01;
            return e;
        end
`endif
        base = int'(a - a % n);
        e.widx = base / 4;
        if (r) begin
            val = 0;
            for (int i = 0; i < n; i++) val += longint'(get_byte(32'(base + i))) << (8 * i);
            if (!f[2] && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= longint'(1) << (8 * n);
            e.ctrl = 2'b10;
            e.lv = 1;
            e.ld = val[31:0];
        end else begin
            nw = ref_mem[e.widx];
            for (int i = 0; i < n; i++) nw[8 * ((base + i) % 4) +: 8] = s[8 * i +: 8];
            e.wr = 1;
            e.wdata = nw;
            e.ctrl = n == 4 ? 2'b01 : 2'b10;
            e.stall = n < 4;
        end
        return e;
    endfunction

    // called at posedge+1; returns at posedge+1 after the request completes
    task automatic apply(input string name, input logic v, r, w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] s);
        exp_t e;
        int c0;
        e = model(v, r, w, f, a, s);
        c0 = wr_count;
        valid = v; rd = r; wr = w; f3 = f; addr = a; sdata = s;
        #5;
        check({name, " ctrl"}, 32'(ctrl), 32'(e.ctrl));
        check({name, " stall"}, 32'(stall), 32'(e.stall));
        if (e.ctrl != 0) check({name, " addr"}, maddr, 32'(e.widx) * 4);
        if (e.ctrl == 2'b01) check({name, " wdata"}, wdata, e.wdata);
        @(posedge clk); #1;
        if (e.stall) begin
            #5;
            check({name, " rmw ctrl"}, 32'(ctrl), 32'h1);
            check({name, " rmw stall"}, 32'(stall), 32'h0);
            check({name, " rmw addr"}, maddr, 32'(e.widx) * 4);
            check({name, " rmw wdata"}, wdata, e.wdata);
            @(posedge clk); #1;
        end
        valid = 0;
        check({name, " lv"}, 32'(lv), 32'(e.lv));
        check({name, " fault"}, 32'(fault), 32'(e.fault));
        if (e.lv) check({name, " ld"}, ld, e.ld);
        if (e.fault != 0) check({name, " bad"}, bad, a);
        if (e.wr) begin
            ref_mem[e.widx] = e.wdata;
            check({name, " mem"}, mem[e.widx], ref_mem[e.widx]);
        end
        check({name, " wrcount"}, 32'(wr_count - c0), 32'(e.wr));
    endtask

    typedef struct {
        logic v, r, w;
        logic [2:0] f;
        logic [31:0] a;
        logic [1:0] ctrl;
        logic [31:0] maddr;
        logic lv;
        logic [31:0] ld;
        logic [1:0] fault;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #3;
        check("rst ctrl", 32'(ctrl), 0);
        check("rst stall", 32'(stall), 0);
        check("rst ld", ld, 0);
        check("rst lv", 32'(lv), 0);
        check("rst fault", 32'(fault), 0);
        check("rst bad", bad, 0);
        for (int i = 0; i < MW; i++) preload(i, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        preload(4, 32'h8899_AABB);
        preload(1, 32'hCAFE_F00D);
        preload(MW - 1, 32'h1357_2468);
        tbl.push_back('{1, 1, 0, 3'b000, 32'h13, 2'b10, 32'h10, 1, 32'hFFFF_FF88, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b100, 32'h13, 2'b10, 32'h10, 1, 32'h0000_0088, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b001, 32'h12, 2'b10, 32'h10, 1, 32'hFFFF_8899, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b101, 32'h10, 2'b10, 32'h10, 1, 32'h0000_AABB, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b010, 32'h10, 2'b10, 32'h10, 1, 32'h8899_AABB, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b000, 32'h10, 2'b10, 32'h10, 1, 32'hFFFF_FFBB, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b101, 32'h12, 2'b10, 32'h10, 1, 32'h0000_8899, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b010, 32'h1FFC, 2'b10, 32'h1FFC, 1, 32'h1357_2468, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b010, 32'h2000, 2'b00, 32'h0, 0, 32'h0, 2'b10});
        tbl.push_back('{1, 0, 1, 3'b010, 32'h2000, 2'b00, 32'h0, 0, 32'h0, 2'b10});
        tbl.push_back('{1, 1, 0, 3'b010, 32'h2002, 2'b00, 32'h0, 0, 32'h0, 2'b10});
        tbl.push_back('{1, 1, 1, 3'b010, 32'h10, 2'b00, 32'h0, 0, 32'h0, 2'b00});
        tbl.push_back('{1, 0, 0, 3'b010, 32'h10, 2'b00, 32'h0, 0, 32'h0, 2'b00});
        tbl.push_back('{0, 1, 0, 3'b010, 32'h10, 2'b00, 32'h0, 0, 32'h0, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b011, 32'h10, 2'b00, 32'h0, 0, 32'h0, 2'b00});
        tbl.push_back('{1, 0, 1, 3'b100, 32'h10, 2'b00, 32'h0, 0, 32'h0, 2'b00});
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        tbl.push_back('{1, 1, 0, 3'b010, 32'h06, 2'b00, 32'h0, 0, 32'h0, 2'b01});
        tbl.push_back('{1, 1, 0, 3'b001, 32'h11, 2'b00, 32'h0, 0, 32'h0, 2'b01});
`else
        tbl.push_back('{1, 1, 0, 3'b010, 32'h06, 2'b10, 32'h04, 1, 32'hCAFE_F00D, 2'b00});
        tbl.push_back('{1, 1, 0, 3'b001, 32'h11, 2'b10, 32'h10, 1, 32'hFFFF_AABB, 2'b00});
`endif
        wc = wr_count;
        foreach (tbl[i]) begin
            valid = tbl[i].v; rd = tbl[i].r; wr = tbl[i].w; f3 = tbl[i].f;
            addr = tbl[i].a; sdata = 32'h5555_AAAA;
            #5;
            check($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(tbl[i].ctrl));
            check($sformatf("vec%0d stall", i), 32'(stall), 0);
            if (tbl[i].ctrl != 0) check($sformatf("vec%0d addr", i), maddr, tbl[i].maddr);
            @(posedge clk); #1;
            valid = 0;
            check($sformatf("vec%0d lv", i), 32'(lv), 32'(tbl[i].lv));
            check($sformatf("vec%0d fault", i), 32'(fault), 32'(tbl[i].fault));
            if (tbl[i].lv) check($sformatf("vec%0d ld", i), ld, tbl[i].ld);
            if (tbl[i].fault != 0) check($sformatf("vec%0d bad", i), bad, tbl[i].a);
        end
        check("vec no writes", 32'(wr_count - wc), 0);

        preload(4, 32'h1122_3344);
        apply("sb", 1, 0, 1, 3'b000, 32'h11, 32'h0000_00CC);
        check("sb merged", mem[4], 32'h1122_CC44);
        apply("lw after sb", 1, 1, 0, 3'b010, 32'h10, 0);
        check("lw after sb ld", ld, 32'h1122_CC44);
        preload(8, 0);
        apply("sh", 1, 0, 1, 3'b001, 32'h22, 32'h0000_BEEF);
        check("sh merged", mem[8], 32'hBEEF_0000);
        apply("lh", 1, 1, 0, 3'b001, 32'h22, 0);
        check("lh ld", ld, 32'hFFFF_BEEF);
        apply("sb oor", 1, 0, 1, 3'b000, 32'h2000, 32'h77);
        check("sb oor bad", bad, 32'h0000_2000);

        preload(12, 32'hA5A5_A5A5);
        wc = wr_count;
        valid = 1; rd = 0; wr = 1; f3 = 3'b000; addr = 32'h31; sdata = 32'h5A;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        check("rstrmw ctrl", 32'(ctrl), 0);
        check("rstrmw stall", 32'(stall), 0);
        @(posedge clk); #1;
        valid = 0;
        rst_n = 1;
        check("rstrmw wrcount", 32'(wr_count - wc), 0);
        check("rstrmw mem", mem[12], 32'hA5A5_A5A5);
        check("rstrmw ld", ld, 0);
        check("rstrmw lv", 32'(lv), 0);
        apply("lw after rst", 1, 1, 0, 3'b010, 32'h30, 0);

        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            int sel;
            sel = int'($urandom_range(0, 9));
            a = sel == 0 ? $urandom : sel == 1 ? 32'h1FF8 + $urandom_range(0, 15) : $urandom_range(0, 255);
            apply("rnd", $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                  3'($urandom), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit between the EX/MEM pipeline register and the word-addressed data memory.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses on the memory's ctrl/addr/data interface.
- Sign- or zero-extends load results.
- Implements sub-word stores as a two-cycle read-modify-write and stalls upstream for the extra cycle.
- Detects misaligned and out-of-range accesses.

Parameters:
- MEM_WORDS, 2048, number of 32-bit words in data memory; a word index >= MEM_WORDS is out of range.

Ports:
- i_clk  input  1  clock
- i_reset_n  input  1  asynchronous active-low reset
- i_valid  input  1  request valid this cycle
- i_memRead  input  1  load request
- i_memWrite  input  1  store request
- i_funct3  input  3  RV32I width/sign code
- i_addr  input  32  byte address
- i_storeData  input  32  store source register value
- i_memReadData  input  32  memory read data, valid after negedge of the cycle in which o_ctrlMEM[1]=1
- o_ctrlMEM  output  2  {read, write} to memory
- o_memAddr  output  32  word-aligned address to memory
- o_memWriteData  output  32  write data to memory
- o_stall  output  1  hold upstream pipeline register
- o_loadData  output  32  extended load result
- o_loadValid  output  1  o_loadData valid pulse
- o_fault  output  2  {addrFault, misaligned} pulse
- o_badAddr  output  32  faulting byte address

Behaviour:
- Reset is i_reset_n, asynchronous, active-low; clock is i_clk.
- Reset values: state=IDLE; o_loadData, o_badAddr, and the RMW address/data registers = 0; o_loadValid=0; o_fault=0.
- Combinational outputs idle at 0 during reset: o_ctrlMEM=00, o_stall=0.
- A request is accepted in IDLE when i_valid=1 and exactly one of i_memRead/i_memWrite is 1. Both set, or neither, is ignored: no access, no fault.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other code is ignored: no access, no fault.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
- Out of range: addr[31:2] >= MEM_WORDS. Out of range takes precedence over misaligned.
- On a fault:
  - o_ctrlMEM=00.
  - Next cycle: o_fault pulses for 1 cycle with the relevant bit set, and o_badAddr <= i_addr.
  - o_loadValid stays 0.
- Address output: o_memAddr={i_addr[31:2],2'b00} in IDLE, and the captured RMW address in RMW_WR.
- Loads (IDLE, 1 cycle, no stall):
  - Drive o_ctrlMEM=10.
  - At the posedge, select the byte/half by addr[1:0] from i_memReadData, extend per funct3, and register it into o_loadData.
  - o_loadValid=1 for exactly 1 cycle after the request cycle.
- SW (IDLE, 1 cycle, no stall): o_ctrlMEM=01, o_memWriteData=i_storeData.
- SB/SH form an FSM {IDLE, RMW_WR}:
  - IDLE cycle:
    - Drive o_ctrlMEM=10 and o_stall=1 combinationally.
    - At the posedge, capture the aligned address and the merged word, then go to RMW_WR.
    - Merged word = i_memReadData with the byte/half lane at addr[1:0] replaced by i_storeData[7:0]/[15:0].
  - RMW_WR cycle:
    - o_ctrlMEM=01, o_memWriteData=merged word, o_stall=0.
    - Inputs are ignored this cycle.
    - Return to IDLE at the posedge.
  - Total 2 cycles; upstream advances at the end of RMW_WR.
- Upstream holds inputs stable while o_stall=1. The LSU uses only the values sampled in the IDLE cycle.
- Reset mid-RMW: go to IDLE immediately; no write issued; the merge register is cleared.
- Lane mapping is little-endian: addr[1:0]=00 selects bits [7:0]; 11 selects bits [31:24]; a halfword at addr[1]=1 selects bits [31:16].

Optional Feature:
- Macro: MEM_LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses are suppressed and reported via o_fault[0], as above.
- Undefined:
  - Misaligned accesses proceed with the address forced to natural alignment: halfword clears addr[0]; word clears addr[1:0].
  - o_fault[0] is tied 0.
  - Out-of-range detection is unaffected.

Test Plan:
- Preload word 0x10 = 0x8899AABB; LB addr 0x13 -> o_loadData=0xFFFFFF88 and o_loadValid=1 one cycle later; LBU addr 0x13 -> 0x00000088.
- SB data 0x000000CC to addr 0x11, word 0x10 preloaded 0x11223344 -> o_stall=1 for 1 cycle, then a write of 0x1122CC44; a following LW returns 0x1122CC44.
- SH data 0x0000BEEF to addr 0x22, word 0x20 preloaded 0 -> a write of 0xBEEF0000; LH addr 0x22 -> 0xFFFFBEEF.
- With the macro defined, LW addr 0x06 -> o_ctrlMEM stays 00, o_fault=01 for 1 cycle, o_badAddr=0x00000006. Without the macro -> the read occurs at 0x04.
- Store to addr MEM_WORDS*4 (0x2000) -> no write, o_fault=10, o_badAddr=0x00002000.
- Assert reset during RMW_WR of an SB -> no write, o_stall=0; the target word is unchanged and o_loadData=0 after reset.
